// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the instruction-decode stage.
// Optional build macro consumed by the stage: RVCAM_DECODE_ILLEGAL_DETECT_EN.

`ifndef DECODE_STAGE_DEFINES
`define DECODE_STAGE_DEFINES

`define XLEN                32
`define OPCODE_LEN          7
`define MAX_IMM_LEN         25
`define IMM_TYPE_BITS_COUNT 3

// Immediate format codes handed to the downstream immediate decoder
`define IMM_TYPE_I 3'd0
`define IMM_TYPE_S 3'd1
`define IMM_TYPE_B 3'd2
`define IMM_TYPE_U 3'd3
`define IMM_TYPE_J 3'd4

// RV32 base opcodes
`define OP_IMM 7'b0010011
`define LOAD   7'b0000011
`define JALR   7'b1100111
`define SYSTEM 7'b1110011
`define STORE  7'b0100011
`define BRANCH 7'b1100011
`define LUI    7'b0110111
`define AUIPC  7'b0010111
`define JAL    7'b1101111
`define OP     7'b0110011

`endif

package decode_stage_pkg;

  // Occupancy of the elastic buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // One fully decoded beat as held in the output or skid register
  typedef struct packed {
    logic [`XLEN-1:0]                pc;
    logic [`OPCODE_LEN-1:0]          opcode;
    logic [4:0]                      rd;
    logic [4:0]                      rs1;
    logic [4:0]                      rs2;
    logic [2:0]                      funct3;
    logic [6:0]                      funct7;
    logic [`MAX_IMM_LEN-1:0]         imm;
    logic [`IMM_TYPE_BITS_COUNT-1:0] imm_type;
    logic                            uses_imm;
    logic                            illegal;
  } dec_beat_t;

endpackage

// File: rtl/decode_stage_opcode_classifier.sv
// Pure combinational opcode classifier: immediate format, immediate usage and
// (with RVCAM_DECODE_ILLEGAL_DETECT_EN) unsupported-encoding detection.

module decode_stage_opcode_classifier
  import decode_stage_pkg::*;
(
  input  logic [`OPCODE_LEN-1:0]          opcode_i,
  output logic [`IMM_TYPE_BITS_COUNT-1:0] imm_type_o,
  output logic                            uses_imm_o,
  output logic                            illegal_o
);

  // Map the opcode onto its immediate format; R-type and unknown opcodes carry none
  always_comb begin
    imm_type_o = `IMM_TYPE_I;
    uses_imm_o = 1'b1;
    case (opcode_i)
      `OP_IMM, `LOAD, `JALR, `SYSTEM: imm_type_o = `IMM_TYPE_I;
      `STORE:                         imm_type_o = `IMM_TYPE_S;
      `BRANCH:                        imm_type_o = `IMM_TYPE_B;
      `LUI, `AUIPC:                   imm_type_o = `IMM_TYPE_U;
      `JAL:                           imm_type_o = `IMM_TYPE_J;
      default:                        uses_imm_o = 1'b0;
    endcase
  end

`ifdef RVCAM_DECODE_ILLEGAL_DETECT_EN
  // Compressed-quadrant low bits or any opcode outside the supported set is illegal;
  // an all-zero word falls out naturally because its opcode is 0000000
  assign illegal_o = (opcode_i[1:0] != 2'b11) ||
                     !(opcode_i inside {`OP_IMM, `LOAD, `JALR, `SYSTEM, `STORE,
                                        `BRANCH, `LUI, `AUIPC, `JAL, `OP});
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: splits fetched words into fields, classifies the
// immediate format and holds decoded beats in a small elastic buffer.
// REGISTERED_READY=1: two-entry skid buffer with a flopped if_ready.
// REGISTERED_READY=0: single register, if_ready = empty || id_ready.
// Optional build macro: RVCAM_DECODE_ILLEGAL_DETECT_EN (drives id_illegal).

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int REGISTERED_READY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            if_valid,
  output logic                            if_ready,
  input  logic [31:0]                     if_instr,
  input  logic [`XLEN-1:0]                if_pc,
  output logic                            id_valid,
  input  logic                            id_ready,
  output logic [`XLEN-1:0]                id_pc,
  output logic [`OPCODE_LEN-1:0]          id_opcode,
  output logic [4:0]                      id_rd,
  output logic [4:0]                      id_rs1,
  output logic [4:0]                      id_rs2,
  output logic [2:0]                      id_funct3,
  output logic [6:0]                      id_funct7,
  output logic [`MAX_IMM_LEN-1:0]         id_imm,
  output logic [`IMM_TYPE_BITS_COUNT-1:0] id_imm_type,
  output logic                            id_uses_imm,
  output logic                            id_illegal
);

  buf_state_e state_q, state_d;
  dec_beat_t  out_q, out_d;
  dec_beat_t  skid_q, skid_d;
  dec_beat_t  in_beat;

  logic                            accept;
  logic                            consume;
  logic [`IMM_TYPE_BITS_COUNT-1:0] cls_imm_type;
  logic                            cls_uses_imm;
  logic                            cls_illegal;

  decode_stage_opcode_classifier u_classifier (
    .opcode_i   (if_instr[6:0]),
    .imm_type_o (cls_imm_type),
    .uses_imm_o (cls_uses_imm),
    .illegal_o  (cls_illegal)
  );

  // Decode the incoming word once, on entry; stored beats are never re-decoded
  always_comb begin
    in_beat          = '0;
    in_beat.pc       = if_pc;
    in_beat.opcode   = if_instr[6:0];
    in_beat.rd       = if_instr[11:7];
    in_beat.funct3   = if_instr[14:12];
    in_beat.rs1      = if_instr[19:15];
    in_beat.rs2      = if_instr[24:20];
    in_beat.funct7   = if_instr[31:25];
    in_beat.imm      = if_instr[31:7];
    in_beat.imm_type = cls_imm_type;
    in_beat.uses_imm = cls_uses_imm;
    in_beat.illegal  = cls_illegal;
  end

  assign id_valid = (state_q != ST_EMPTY);
  // A beat offered during flush is dropped even when if_ready is high
  assign accept   = if_valid && if_ready && !flush;
  assign consume  = id_valid && id_ready;

  generate
    if (REGISTERED_READY != 0) begin : g_reg_ready
      logic if_ready_q;

      // Ready is a flop: low exactly when the next state holds two beats
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          if_ready_q <= 1'b1;
        end else begin
          if_ready_q <= (state_d != ST_TWO);
        end
      end

      assign if_ready = if_ready_q;
    end else begin : g_comb_ready
      assign if_ready = (state_q == ST_EMPTY) || id_ready;
    end
  endgenerate

  // Buffer occupancy and data movement; flush overrides everything
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = in_beat;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_d = in_beat;
          end else if (accept && (REGISTERED_READY != 0)) begin
            skid_d  = in_beat;
            state_d = ST_TWO;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // if_ready is low here, so only the skid-to-output move can occur
          if (consume) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and beat registers; reset clears held beats and zeroes the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign id_pc       = out_q.pc;
  assign id_opcode   = out_q.opcode;
  assign id_rd       = out_q.rd;
  assign id_rs1      = out_q.rs1;
  assign id_rs2      = out_q.rs2;
  assign id_funct3   = out_q.funct3;
  assign id_funct7   = out_q.funct7;
  assign id_imm      = out_q.imm;
  assign id_imm_type = out_q.imm_type;
  assign id_uses_imm = out_q.uses_imm;
  assign id_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (default REGISTERED_READY=1).
// A queue-based reference model tracks held beats; every decoded field is
// derived from the raw instruction word of the beat at the queue head.

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        id_ready = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;

  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [24:0] id_imm;
  logic [2:0]  id_imm_type;
  logic        id_uses_imm;
  logic        id_illegal;

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_opcode   (id_opcode),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_funct3   (id_funct3),
    .id_funct7   (id_funct7),
    .id_imm      (id_imm),
    .id_imm_type (id_imm_type),
    .id_uses_imm (id_uses_imm),
    .id_illegal  (id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

`ifdef RVCAM_DECODE_ILLEGAL_DETECT_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate format straight from the opcode table
  function automatic logic [2:0] exp_type(input logic [6:0] op);
    case (op)
      7'b0100011:             return `IMM_TYPE_S;
      7'b1100011:             return `IMM_TYPE_B;
      7'b0110111, 7'b0010111: return `IMM_TYPE_U;
      7'b1101111:             return `IMM_TYPE_J;
      default:                return `IMM_TYPE_I;
    endcase
  endfunction

  function automatic logic exp_uses(input logic [6:0] op);
    return op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                      7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
    if (!ILL_EN) return 1'b0;
    return (w[1:0] != 2'b11) || !(exp_uses(w[6:0]) || (w[6:0] == 7'b0110011));
  endfunction

  // Reference model: held beats in arrival order, at most two
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    int sz;
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        sz = q.size();
        if (sz != 0 && id_ready) void'(q.pop_front());
        if (if_valid && sz < 2) q.push_back('{if_instr, if_pc});
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_data", 64'({id_pc, id_imm}), 64'd0);
    end else begin
      chk("id_valid", 64'(id_valid), 64'(q.size() != 0));
      chk("if_ready", 64'(if_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        b = q[0];
        chk("id_pc",       64'(id_pc),       64'(b.pc));
        chk("id_opcode",   64'(id_opcode),   64'(b.instr[6:0]));
        chk("id_rd",       64'(id_rd),       64'(b.instr[11:7]));
        chk("id_funct3",   64'(id_funct3),   64'(b.instr[14:12]));
        chk("id_rs1",      64'(id_rs1),      64'(b.instr[19:15]));
        chk("id_rs2",      64'(id_rs2),      64'(b.instr[24:20]));
        chk("id_funct7",   64'(id_funct7),   64'(b.instr[31:25]));
        chk("id_imm",      64'(id_imm),      64'(b.instr >> 7));
        chk("id_imm_type", 64'(id_imm_type), 64'(exp_type(b.instr[6:0])));
        chk("id_uses_imm", 64'(id_uses_imm), 64'(exp_uses(b.instr[6:0])));
        chk("id_illegal",  64'(id_illegal),  64'(exp_illegal(b.instr)));
      end
    end
  end

  // Advance to just after the next falling edge, where inputs are changed
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic        uses;
  } fmt_vec_t;

  fmt_vec_t    fmt[5];
  logic [31:0] stream[5];
  int          idx;
  bit          saw_not_ready;

  initial begin
    fmt[0] = '{32'h00112023, `IMM_TYPE_S, 1'b1};
    fmt[1] = '{32'h00000063, `IMM_TYPE_B, 1'b1};
    fmt[2] = '{32'h123450B7, `IMM_TYPE_U, 1'b1};
    fmt[3] = '{32'h0000006F, `IMM_TYPE_J, 1'b1};
    fmt[4] = '{32'h002081B3, `IMM_TYPE_I, 1'b0};
    stream[0] = 32'hFFF10093;
    stream[1] = 32'h00112023;
    stream[2] = 32'h123450B7;
    stream[3] = 32'h002081B3;
    stream[4] = 32'h0000006F;

    // Reset with a definite falling edge on rst_n
    #1 rst_n = 1'b0;
    step();
    step();
    chk("reset_id_valid", 64'(id_valid), 64'd0);
    chk("reset_id_pc", 64'(id_pc), 64'd0);
    chk("reset_id_imm", 64'(id_imm), 64'd0);
    rst_n = 1'b1;
    step();
    chk("reset_if_ready", 64'(if_ready), 64'd1);

    // Basic decode: addi x1,x2,-1
    id_ready = 1'b1;
    if_valid = 1'b1;
    if_instr = 32'hFFF10093;
    if_pc    = 32'h100;
    step();
    if_valid = 1'b0;
    chk("basic_valid", 64'(id_valid), 64'd1);
    chk("basic_rd", 64'(id_rd), 64'd1);
    chk("basic_rs1", 64'(id_rs1), 64'd2);
    chk("basic_funct3", 64'(id_funct3), 64'd0);
    chk("basic_imm", 64'(id_imm), 64'h1FFE201);
    chk("basic_type", 64'(id_imm_type), 64'(`IMM_TYPE_I));
    chk("basic_uses", 64'(id_uses_imm), 64'd1);
    chk("basic_illegal", 64'(id_illegal), 64'd0);
    step();

    // Format sweep, back to back with execute always ready
    for (int i = 0; i < 5; i++) begin
      if_valid = 1'b1;
      if_instr = fmt[i].instr;
      if_pc    = 32'h180 + 32'(4 * i);
      step();
      chk("fmt_valid", 64'(id_valid), 64'd1);
      chk("fmt_type", 64'(id_imm_type), 64'(fmt[i].typ));
      chk("fmt_uses", 64'(id_uses_imm), 64'(fmt[i].uses));
      if (i == 2) chk("fmt_u_rd", 64'(id_rd), 64'd1);
      if (i == 4) chk("fmt_r_rs2", 64'(id_rs2), 64'd2);
    end
    if_valid = 1'b0;
    step();

    // Back-pressure: five beats, execute stalls for three cycles
    idx = 0;
    saw_not_ready = 1'b0;
    for (int c = 0; c < 30 && (idx < 5 || q.size() != 0); c++) begin
      id_ready = !(c >= 1 && c <= 3);
      if_valid = (idx < 5);
      if (idx < 5) begin
        if_instr = stream[idx];
        if_pc    = 32'h200 + 32'(4 * idx);
      end
      if (!if_ready) saw_not_ready = 1'b1;
      if (if_valid && if_ready) idx++;
      step();
    end
    if_valid = 1'b0;
    chk("bp_all_sent", 64'(idx), 64'd5);
    chk("bp_ready_dropped", 64'(saw_not_ready), 64'd1);
    step();

    // Flush while two beats are held, with a beat offered in the flush cycle
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_instr = 32'h00500293;
    if_pc    = 32'h300;
    step();
    if_instr = 32'h00600313;
    if_pc    = 32'h304;
    step();
    chk("flush_pre_ready", 64'(if_ready), 64'd0);
    flush    = 1'b1;
    if_instr = 32'h00700393;
    if_pc    = 32'h308;
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_ready", 64'(if_ready), 64'd1);
    // A beat offered during flush with if_ready high is also dropped
    if_valid = 1'b1;
    if_instr = 32'h00800413;
    if_pc    = 32'h30C;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b1;
    chk("flush_drop_valid", 64'(id_valid), 64'd0);
    step();
    chk("flush_stays_empty", 64'(id_valid), 64'd0);

    // Asynchronous reset mid-stream
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_instr = 32'h00900493;
    if_pc    = 32'h400;
    step();
    if_valid = 1'b0;
    chk("mid_held", 64'(id_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(id_valid), 64'd0);
    chk("mid_rst_pc", 64'(id_pc), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    id_ready = 1'b1;
    if_valid = 1'b1;
    if_instr = 32'h00A00513;
    if_pc    = 32'h404;
    step();
    if_valid = 1'b0;
    chk("post_rst_valid", 64'(id_valid), 64'd1);
    chk("post_rst_pc", 64'(id_pc), 64'h404);
    step();

    // Illegal-encoding detection
    if_valid = 1'b1;
    if_instr = 32'h0000007F;
    if_pc    = 32'h500;
    step();
    chk("ill_7f", 64'(id_illegal), 64'(ILL_EN));
    if_instr = 32'h00000000;
    if_pc    = 32'h504;
    step();
    chk("ill_zero", 64'(id_illegal), 64'(ILL_EN));
    if_instr = 32'hFFF10093;
    if_pc    = 32'h508;
    step();
    if_valid = 1'b0;
    chk("ill_addi", 64'(id_illegal), 64'd0);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
